// File: rtl/colour_rom_arbiter.sv
// Two-requester arbiter for a single-port colour ROM with a 1-cycle synchronous read.
// Define COLOUR_ARB_FIXED_PRIO_EN to make requester 0 always win a conflict (default: round-robin).
module colour_rom_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rdata
);

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;

  logic              r_pend_vld_p1;
  logic              r_pend_id_p1;
  logic              r_rvalid0_p2;
  logic              r_rvalid1_p2;
  logic [DATA_W-1:0] r_rdata_p2;

`ifdef COLOUR_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      w_gnt0 = req0;
      w_gnt1 = req1 & ~req0;
    end
  end
`else
  // r_prio names the requester that wins the next conflict
  logic r_prio;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        w_gnt0 = ~r_prio;
        w_gnt1 = r_prio;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_gnt0) begin
      r_prio <= 1'b1;
    end else if (w_gnt1) begin
      r_prio <= 1'b0;
    end
  end
`endif

  always_comb begin
    w_en   = w_gnt0 | w_gnt1;
    w_addr = '0;
    if (w_gnt1) begin
      w_addr = addr1;
    end else if (w_gnt0) begin
      w_addr = addr0;
    end
  end

  // Stage 1: remember which requester owns the ROM read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld_p1 <= 1'b0;
      r_pend_id_p1  <= 1'b0;
    end else begin
      r_pend_vld_p1 <= w_en;
      r_pend_id_p1  <= w_gnt1;
    end
  end

  // Stage 2: capture ROM data and steer the valid to its owner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid0_p2 <= 1'b0;
      r_rvalid1_p2 <= 1'b0;
      r_rdata_p2   <= '0;
    end else begin
      r_rvalid0_p2 <= r_pend_vld_p1 & ~r_pend_id_p1;
      r_rvalid1_p2 <= r_pend_vld_p1 & r_pend_id_p1;
      if (r_pend_vld_p1) begin
        r_rdata_p2 <= rom_data;
      end
    end
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign rom_en   = w_en;
  assign rom_addr = w_addr;
  assign rvalid0  = r_rvalid0_p2;
  assign rvalid1  = r_rvalid1_p2;
  assign rdata    = r_rdata_p2;

endmodule

// File: tb/tb_colour_rom_arbiter.sv
// Bench for colour_rom_arbiter: directed scenarios plus randomized traffic against a
// cycle-indexed reference model (who wins next, which results are due in which cycle).
module tb_colour_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [2:0]  addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, rom_en;
  logic [2:0]  rom_addr;
  logic [23:0] rom_data;
  logic [23:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  colour_rom_arbiter #(.ADDR_W(3), .DATA_W(24)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: mem[i] = 24'h0F0F00 + i, one-cycle read latency
  always @(posedge clk) begin
    if (rom_en) rom_data <= 24'h0F0F00 + 24'(rom_addr);
  end

  // Reference model state: results due per cycle (ring), next conflict winner, last rdata
  logic        m_v  [0:1023];
  logic        m_id [0:1023];
  logic [23:0] m_d  [0:1023];
  int          cyc = 0;
  int          m_turn = 0;
  logic        m_prev_rst = 1'b1;
  logic [23:0] m_rdata = 24'h0;

  logic        e_g0, e_g1, e_en, e_rv0, e_rv1;
  logic [2:0]  e_addr;
  logic [23:0] e_rd;

  task automatic drive_cycle(input logic r, input logic q0, input logic [2:0] a0,
                             input logic q1, input logic [2:0] a1);
    int idx;
    logic ev, eid;
    @(posedge clk);
    #1;
    rst = r; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
    #3;
    idx = cyc % 1024;
    ev  = m_v[idx];
    eid = m_id[idx];
    m_v[idx] = 1'b0;
    if (ev) m_rdata = m_d[idx];
    else if (m_prev_rst) m_rdata = 24'h0;
    e_rv0 = ev & ~eid;
    e_rv1 = ev & eid;
    e_rd  = m_rdata;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!r) begin
      if (q0 && q1) begin
`ifdef COLOUR_ARB_FIXED_PRIO_EN
        e_g0 = 1'b1;
`else
        if (m_turn == 0) e_g0 = 1'b1;
        else e_g1 = 1'b1;
`endif
      end else begin
        e_g0 = q0;
        e_g1 = q1;
      end
    end
    e_en   = e_g0 | e_g1;
    e_addr = e_g1 ? a1 : (e_g0 ? a0 : 3'd0);
    if (e_en) begin
      m_v[(cyc + 2) % 1024]  = 1'b1;
      m_id[(cyc + 2) % 1024] = e_g1;
      m_d[(cyc + 2) % 1024]  = 24'h0F0F00 + 24'(e_addr);
      m_turn = e_g1 ? 0 : 1;
    end
    if (r) begin
      m_turn = 0;
      m_v[(cyc + 1) % 1024] = 1'b0;
    end
    m_prev_rst = r;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 3'd1, 1'b1, 3'd2);
      n_tests++;
      if ({gnt0, gnt1, rom_en, rvalid0, rvalid1, rdata} !== {4'b0000, 1'b0, 24'h000000}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got g=%b%b en=%b rv=%b%b d=%h, want all zero", i, gnt0, gnt1, rom_en, rvalid0, rvalid1, rdata);
      end
      n_tests++;
      if ({gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata} !== {e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd}) begin
        n_fail++;
        $display("FAIL reset_model: got g=%b%b en=%b a=%0d rv=%b%b d=%h want g=%b%b en=%b a=%0d rv=%b%b d=%h",
                 gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata, e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd);
      end
    end
  endtask

  task automatic test_single_read();
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, k == 0, 3'd5, 1'b0, 3'd0);
      n_tests++;
      if ({gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata} !== {e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd}) begin
        n_fail++;
        $display("FAIL single_model: got g=%b%b en=%b a=%0d rv=%b%b d=%h want g=%b%b en=%b a=%0d rv=%b%b d=%h",
                 gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata, e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd);
      end
      if (k == 0) begin
        n_tests++;
        if ({gnt0, rom_addr} !== {1'b1, 3'd5}) begin
          n_fail++;
          $display("FAIL single_grant: got gnt0=%b rom_addr=%0d, want 1 / 5", gnt0, rom_addr);
        end
      end
      if (k == 2) begin
        n_tests++;
        if ({rvalid0, rvalid1, rdata} !== {1'b1, 1'b0, 24'h0F0F05}) begin
          n_fail++;
          $display("FAIL single_result: got rv=%b%b d=%h, want 10 0f0f05", rvalid0, rvalid1, rdata);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic        gseq [0:3];
    logic        rvseq [0:3];
    logic [23:0] dseq [0:3];
    logic        exp_g1 [0:3];
    drive_cycle(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1'b0, k < 4, 3'd2, k < 4, 3'd6);
      n_tests++;
      if ({gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata} !== {e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd}) begin
        n_fail++;
        $display("FAIL rr_model: got g=%b%b en=%b a=%0d rv=%b%b d=%h want g=%b%b en=%b a=%0d rv=%b%b d=%h",
                 gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata, e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd);
      end
      if (k < 4) gseq[k] = gnt1;
      if (k >= 2) begin
        rvseq[k-2] = rvalid1;
        dseq[k-2]  = rdata;
      end
    end
`ifdef COLOUR_ARB_FIXED_PRIO_EN
    exp_g1 = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g1 = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({gseq[k], rvseq[k], dseq[k]} !== {exp_g1[k], exp_g1[k], (exp_g1[k] ? 24'h0F0F06 : 24'h0F0F02)}) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got gnt1=%b rvalid1=%b d=%h, want gnt1=%b rvalid1=%b", k, gseq[k], rvseq[k], dseq[k], exp_g1[k], exp_g1[k]);
      end
    end
`ifdef COLOUR_ARB_FIXED_PRIO_EN
    drive_cycle(1'b0, 1'b0, 3'd2, 1'b1, 3'd6);
    n_tests++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL fixed_drop: got g=%b%b, want 01", gnt0, gnt1);
    end
`endif
  endtask

  task automatic test_stall_hold();
    drive_cycle(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 1'b1, 3'(k), k == 3, 3'd7);
      n_tests++;
      if ({gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata} !== {e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd}) begin
        n_fail++;
        $display("FAIL stall_model: got g=%b%b en=%b a=%0d rv=%b%b d=%h want g=%b%b en=%b a=%0d rv=%b%b d=%h",
                 gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata, e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd);
      end
    end
    n_tests++;
`ifdef COLOUR_ARB_FIXED_PRIO_EN
    if ({gnt0, gnt1, rom_addr} !== {2'b10, 3'd3}) begin
`else
    if ({gnt0, gnt1, rom_addr} !== {2'b01, 3'd7}) begin
`endif
      n_fail++;
      $display("FAIL stall_conflict: got g=%b%b a=%0d", gnt0, gnt1, rom_addr);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    drive_cycle(1'b0, 1'b0, 3'd0, 1'b1, 3'd3);
    n_tests++;
    if (gnt1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_grant: got gnt1=%b, want 1", gnt1);
    end
    drive_cycle(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      if (rvalid0 || rvalid1) seen = 1'b1;
      if (k == 0) begin
        n_tests++;
        if ({rvalid1, rdata} !== {1'b0, 24'h0}) begin
          n_fail++;
          $display("FAIL midflight_drop: got rvalid1=%b d=%h, want 0 000000", rvalid1, rdata);
        end
      end
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_late: got a result after reset, want none");
    end
  endtask

  task automatic test_random();
    logic       q0, q1, r;
    logic [2:0] a0, a1;
    q0 = 1'b0; q1 = 1'b0; a0 = 3'd0; a1 = 3'd0;
    for (int k = 0; k < 400; k++) begin
      if (!q0 || $urandom_range(0, 9) == 0) begin
        q0 = $urandom_range(0, 2) != 0;
        a0 = 3'($urandom);
      end
      if (!q1 || $urandom_range(0, 9) == 0) begin
        q1 = $urandom_range(0, 2) != 0;
        a1 = 3'($urandom);
      end
      r = ($urandom_range(0, 49) == 0);
      drive_cycle(r, q0, a0, q1, a1);
      n_tests++;
      if ({gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata} !== {e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd}) begin
        n_fail++;
        $display("FAIL random[%0d]: got g=%b%b en=%b a=%0d rv=%b%b d=%h want g=%b%b en=%b a=%0d rv=%b%b d=%h",
                 k, gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata, e_g0, e_g1, e_en, e_addr, e_rv0, e_rv1, e_rd);
      end
      if (gnt0) q0 = 1'b0;
      if (gnt1) q1 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 3'd0; addr1 = 3'd0;
    for (int i = 0; i < 1024; i++) begin
      m_v[i] = 1'b0; m_id[i] = 1'b0; m_d[i] = 24'h0;
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall_hold();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
